// File: rtl/bram_write_pkg.sv
// Shared types and constants for the BRAM write path.
// State encodings are the same ones the BRAM reader uses.
package bram_write_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd2
  } state_e;

  localparam int FIFO_SLOTS     = 4;
  localparam int FIFO_LOG_SLOTS = 2;

endpackage

// File: rtl/bram_write_fifo.sv
// Small circular FIFO that buffers upstream words ahead of the BRAM writer.
// Pushes while full and pops while empty are ignored.
module bram_write_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o
);

  localparam logic [LOG_NUM_SLOTS:0] FULL_COUNT   = (LOG_NUM_SLOTS + 1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0] ALMOST_COUNT = (LOG_NUM_SLOTS + 1)'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wrPtr_q, rdPtr_q;
  logic [LOG_NUM_SLOTS:0]   count_q, count_d;
  logic                     doPush, doPop;

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == FULL_COUNT);
  assign almost_full_o = (count_q >= ALMOST_COUNT);
  assign doPush        = push_i & ~full_o;
  assign doPop         = pop_i & ~empty_o;
  assign data_o        = mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (!doPush && doPop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/bram_write.sv
// Drains a buffered upstream stream into a BRAM as sequential writes,
// rewriting the same address window once per configured iteration.
module bram_write
  import bram_write_pkg::*;
#(
  parameter int DATA_WIDTH              = 8,
  parameter int LOG_MAX_ITERS           = 16,
  parameter int LOG_MAX_WRITES_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS         = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               configure_i,
  input  logic [LOG_MAX_ITERS-1:0]           num_iters_i,
  input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter_i,
  input  logic [LOG_MAX_ADDRESS-1:0]         base_address_i,
  input  logic                               valid_in_i,
  input  logic [DATA_WIDTH-1:0]              data_in_i,
  output logic                               avail_out_o,
  output logic [LOG_MAX_ADDRESS-1:0]         address_out_o,
  output logic [DATA_WIDTH-1:0]              data_out_o,
  output logic                               write_out_o,
  output logic                               done_o,
  output logic                               overflow_o
);

  localparam logic [LOG_MAX_ITERS-1:0]           ITERS_ONE = 1;
  localparam logic [LOG_MAX_WRITES_PER_ITER-1:0] WR_ONE    = 1;

  state_e state_q, state_d;

  logic                               enabled_q, enabled_d;
  logic [LOG_MAX_ITERS-1:0]           itersLeft_q, itersLeft_d;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] wrLeft_q, wrLeft_d, wrCopy_q, wrCopy_d;
  logic [LOG_MAX_ADDRESS-1:0]         addr_q, addr_d, baseCopy_q, baseCopy_d;
  logic [LOG_MAX_ADDRESS-1:0]         addressOut_q, addressOut_d;
  logic [DATA_WIDTH-1:0]              dataOut_q, dataOut_d;
  logic                               writeOut_q, writeOut_d;
  logic                               done_q, done_d;
  logic                               overflow_q;

  logic                  doWrite;
  logic [DATA_WIDTH-1:0] fifoHead;
  logic                  fifoEmpty, fifoFull, fifoAlmostFull;

  bram_write_fifo #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_SLOTS    (FIFO_SLOTS),
    .LOG_NUM_SLOTS(FIFO_LOG_SLOTS)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (valid_in_i),
    .data_i       (data_in_i),
    .pop_i        (doWrite),
    .data_o       (fifoHead),
    .empty_o      (fifoEmpty),
    .full_o       (fifoFull),
    .almost_full_o(fifoAlmostFull)
  );

  // A write is suppressed when configure arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    doWrite = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enabled_q && !fifoEmpty) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (fifoEmpty || !enabled_q) state_d = ST_IDLE;
        else                         doWrite = ~configure_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    enabled_d    = enabled_q;
    itersLeft_d  = itersLeft_q;
    wrLeft_d     = wrLeft_q;
    wrCopy_d     = wrCopy_q;
    addr_d       = addr_q;
    baseCopy_d   = baseCopy_q;
    addressOut_d = addressOut_q;
    dataOut_d    = dataOut_q;
    writeOut_d   = 1'b0;
    done_d       = 1'b0;
    if (configure_i) begin
      enabled_d   = (|num_iters_i) & (|num_writes_per_iter_i);
      itersLeft_d = num_iters_i;
      wrLeft_d    = num_writes_per_iter_i;
      wrCopy_d    = num_writes_per_iter_i;
      addr_d      = base_address_i;
      baseCopy_d  = base_address_i;
    end else if (doWrite) begin
      writeOut_d   = 1'b1;
      addressOut_d = addr_q;
      dataOut_d    = fifoHead;
      if (wrLeft_q != WR_ONE) begin
        wrLeft_d = wrLeft_q - 1'b1;
        addr_d   = addr_q + 1'b1;
      end else if (itersLeft_q == ITERS_ONE) begin
        enabled_d = 1'b0;
        done_d    = 1'b1;
      end else begin
        itersLeft_d = itersLeft_q - 1'b1;
        wrLeft_d    = wrCopy_q;
        addr_d      = baseCopy_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      enabled_q    <= 1'b0;
      itersLeft_q  <= '0;
      wrLeft_q     <= '0;
      wrCopy_q     <= '0;
      addr_q       <= '0;
      baseCopy_q   <= '0;
      addressOut_q <= '0;
      dataOut_q    <= '0;
      writeOut_q   <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enabled_q    <= enabled_d;
      itersLeft_q  <= itersLeft_d;
      wrLeft_q     <= wrLeft_d;
      wrCopy_q     <= wrCopy_d;
      addr_q       <= addr_d;
      baseCopy_q   <= baseCopy_d;
      addressOut_q <= addressOut_d;
      dataOut_q    <= dataOut_d;
      writeOut_q   <= writeOut_d;
      done_q       <= done_d;
      overflow_q   <= overflow_q | (valid_in_i & fifoFull);
    end
  end

  assign avail_out_o   = enabled_q & ~fifoAlmostFull;
  assign address_out_o = addressOut_q;
  assign data_out_o    = dataOut_q;
  assign write_out_o   = writeOut_q;
  assign done_o        = done_q;
  assign overflow_o    = overflow_q;

endmodule
